// File: rtl/serial_bus_pkg.sv
// Shared definitions for the single-wire serial bus: FSM encoding, line levels
// and the effective frame-length clamp.
package serial_bus_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ID,
      ST_RW,
      ST_WDATA,
      ST_RD_WAIT,
      ST_RD_START,
      ST_RD_DATA,
      ST_RD_STOP,
      ST_SKIP_W,
      ST_SKIP_WAIT,
      ST_SKIP_RD
   } state_e;

   localparam logic RW_WRITE    = 1'b1;
   localparam logic RW_READ     = 1'b0;
   localparam logic START_LEVEL = 1'b0;
   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic STOP_LEVEL  = 1'b1;

   // A zero or oversized bit_length selects the full data width.
   function automatic int unsigned eff_len(input int unsigned bl, input int unsigned dw);
      return (bl == 0 || bl > dw) ? dw : bl;
   endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Loadable down-counter that saturates at zero; done flags the terminal count.
// Shared by the ID, data, skip and timeout phases of the slave port.
module serial_bit_counter #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/serial_slave_port.sv
// Slave end of the single-wire serial bus: decodes master frames, delivers
// write words on a parallel port and turns the line around for read responses.
module serial_slave_port
   import serial_bus_pkg::*;
#(
   parameter int                  DATA_WIDTH = 14,
   parameter int                  BIT_LENGTH = 4,
   parameter int                  ID_WIDTH   = 4,
   parameter logic [ID_WIDTH-1:0] SLAVE_ID   = 4'd1,
   parameter int                  RD_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  en,
   input  logic [BIT_LENGTH-1:0] bit_length,
   inout  wire                   serial_port,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_dv,
   output logic                  rd_req,
   input  logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  rd_valid,
   output logic                  busy,
   output logic                  frame_err,
   output state_e                dbg_state
);

   localparam int CNT_MAX = (RD_TIMEOUT > DATA_WIDTH) ? RD_TIMEOUT : DATA_WIDTH;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] DW_C = CNT_W'(DATA_WIDTH);

   state_e                state;
   logic                  line_in;
   logic                  line_oe;
   logic                  line_val;
   logic [ID_WIDTH-1:0]   id_sh;
   logic [DATA_WIDTH-1:0] sh;
   logic [CNT_W-1:0]      n_len;
   logic [CNT_W-1:0]      cur_len;
   logic                  cnt_load;
   logic [CNT_W-1:0]      cnt_val;
   logic                  cnt_done;

   assign line_in     = serial_port;
   assign serial_port = line_oe ? line_val : 1'bz;
   assign cur_len     = CNT_W'(eff_len(32'(bit_length), 32'(DATA_WIDTH)));
   assign busy        = (state != ST_IDLE);
   assign dbg_state   = state;

   // Each phase preloads the count it needs; done fires on the phase's last cycle.
   always_comb begin
      cnt_load = 1'b0;
      cnt_val  = '0;
      case (state)
         ST_IDLE: begin
            if (line_in == START_LEVEL) begin
               cnt_load = 1'b1;
               cnt_val  = CNT_W'(ID_WIDTH - 1);
            end
         end
         ST_RW: begin
            cnt_load = 1'b1;
            if (line_in == RW_WRITE)     cnt_val = cur_len - CNT_W'(1);
            else if (id_sh == SLAVE_ID)  cnt_val = CNT_W'(RD_TIMEOUT - 1);
            else                         cnt_val = CNT_W'(RD_TIMEOUT);
         end
         ST_RD_START: begin
            cnt_load = 1'b1;
            cnt_val  = n_len - CNT_W'(1);
         end
         ST_SKIP_WAIT: begin
            if (line_in == START_LEVEL) begin
               cnt_load = 1'b1;
               cnt_val  = n_len;
            end
         end
         default: ;
      endcase
   end

   serial_bit_counter #(.W(CNT_W)) u_cnt (
      .clk      (clk),
      .rstn     (rstn),
      .load     (cnt_load),
      .load_val (cnt_val),
      .done     (cnt_done)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= ST_IDLE;
         wr_data   <= '0;
         wr_dv     <= 1'b0;
         rd_req    <= 1'b0;
         frame_err <= 1'b0;
         line_oe   <= 1'b0;
         line_val  <= IDLE_LEVEL;
         id_sh     <= '0;
         sh        <= '0;
         n_len     <= DW_C;
      end else begin
         wr_dv     <= 1'b0;
         frame_err <= 1'b0;
         if (!en) begin
            state    <= ST_IDLE;
            rd_req   <= 1'b0;
            line_oe  <= 1'b0;
            line_val <= IDLE_LEVEL;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (line_in == START_LEVEL) state <= ST_ID;
               end
               ST_ID: begin
                  id_sh <= {id_sh[ID_WIDTH-2:0], line_in};
                  if (cnt_done) state <= ST_RW;
               end
               ST_RW: begin
                  n_len <= cur_len;
                  if (id_sh == SLAVE_ID) begin
                     if (line_in == RW_READ) begin
                        state  <= ST_RD_WAIT;
                        rd_req <= 1'b1;
                     end else begin
                        state <= ST_WDATA;
                     end
                  end else begin
                     state <= (line_in == RW_READ) ? ST_SKIP_WAIT : ST_SKIP_W;
                  end
               end
               ST_WDATA: begin
                  sh <= {line_in, sh[DATA_WIDTH-1:1]};
                  if (cnt_done) begin
                     // Bits arrive at the top of the shifter; realign to LSB.
                     wr_data <= {line_in, sh[DATA_WIDTH-1:1]} >> (DW_C - n_len);
                     wr_dv   <= 1'b1;
                     state   <= ST_IDLE;
                  end
               end
               ST_RD_WAIT: begin
                  if (rd_req && rd_valid) begin
                     sh       <= rd_data;
                     rd_req   <= 1'b0;
                     line_oe  <= 1'b1;
                     line_val <= START_LEVEL;
                     state    <= ST_RD_START;
                  end else if (cnt_done) begin
                     rd_req    <= 1'b0;
                     frame_err <= 1'b1;
                     state     <= ST_IDLE;
                  end
               end
               ST_RD_START: begin
                  line_val <= sh[0];
                  sh       <= sh >> 1;
                  state    <= ST_RD_DATA;
               end
               ST_RD_DATA: begin
                  if (cnt_done) begin
                     line_val <= STOP_LEVEL;
                     state    <= ST_RD_STOP;
                  end else begin
                     line_val <= sh[0];
                     sh       <= sh >> 1;
                  end
               end
               ST_RD_STOP: begin
                  line_oe  <= 1'b0;
                  line_val <= IDLE_LEVEL;
                  state    <= ST_IDLE;
               end
               ST_SKIP_W: begin
                  if (cnt_done) state <= ST_IDLE;
               end
               ST_SKIP_WAIT: begin
                  // A foreign responder's start bit must not be taken as a new frame.
                  if (line_in == START_LEVEL) state <= ST_SKIP_RD;
                  else if (cnt_done)          state <= ST_IDLE;
               end
               ST_SKIP_RD: begin
                  if (cnt_done) state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serial_slave_port.sv
// Directed bench for serial_slave_port: plays the bus master (and a foreign
// slave) on the shared line and checks the local parallel port.
module tb_serial_slave_port;
   import serial_bus_pkg::*;

   localparam int DW = 14;

   logic          clk = 1'b0;
   logic          rstn;
   logic          en;
   logic [3:0]    bit_length;
   wire           serial_port;
   logic [DW-1:0] wr_data;
   logic          wr_dv;
   logic          rd_req;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          busy;
   logic          frame_err;
   state_e        dbg_state;

   logic m_oe;
   logic m_val;

   int n_checks = 0;
   int n_pass   = 0;
   int dv_cnt, oe_cnt, req_cnt, ferr_cnt;

   pullup (serial_port);
   assign serial_port = m_oe ? m_val : 1'bz;

   always #5 clk = ~clk;

   serial_slave_port #(
      .DATA_WIDTH (DW),
      .BIT_LENGTH (4),
      .ID_WIDTH   (4),
      .SLAVE_ID   (4'd1),
      .RD_TIMEOUT (16)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .en          (en),
      .bit_length  (bit_length),
      .serial_port (serial_port),
      .wr_data     (wr_data),
      .wr_dv       (wr_dv),
      .rd_req      (rd_req),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .busy        (busy),
      .frame_err   (frame_err),
      .dbg_state   (dbg_state)
   );

   always @(negedge clk) begin
      if (wr_dv)       dv_cnt++;
      if (dut.line_oe) oe_cnt++;
      if (rd_req)      req_cnt++;
      if (frame_err)   ferr_cnt++;
   end

   task automatic clear_counts();
      dv_cnt = 0; oe_cnt = 0; req_cnt = 0; ferr_cnt = 0;
   endtask

   task automatic send_bit(input logic b);
      m_oe = 1'b1; m_val = b;
      @(negedge clk);
   endtask

   task automatic release_line();
      m_oe = 1'b0; m_val = 1'b1;
   endtask

   // Start bit, ID MSB first, RW; returns at the negedge after the RW sample.
   task automatic send_hdr(input logic [3:0] id, input logic rw);
      send_bit(1'b0);
      for (int i = 3; i >= 0; i--) send_bit(id[i]);
      send_bit(rw);
   endtask

   task automatic send_data(input logic [DW-1:0] d, input int n);
      for (int i = 0; i < n; i++) send_bit(d[i]);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (wr_data !== 14'h0) $display("FAIL rst_wr_data: got %h want 0", wr_data); else n_pass++;
      n_checks++; if (wr_dv !== 1'b0) $display("FAIL rst_wr_dv: got %b want 0", wr_dv); else n_pass++;
      n_checks++; if (rd_req !== 1'b0) $display("FAIL rst_rd_req: got %b want 0", rd_req); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (frame_err !== 1'b0) $display("FAIL rst_frame_err: got %b want 0", frame_err); else n_pass++;
      n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL rst_state: got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
      n_checks++; if (dut.line_oe !== 1'b0) $display("FAIL rst_line_oe: got %b want 0", dut.line_oe); else n_pass++;
      rstn = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_write();
      clear_counts();
      bit_length = 4'd8;
      send_hdr(4'd1, 1'b1);
      send_data(14'h00A5, 8);
      release_line();
      n_checks++; if (wr_dv !== 1'b1) $display("FAIL wr_dv_pulse: got %b want 1", wr_dv); else n_pass++;
      n_checks++; if (wr_data !== 14'h00A5) $display("FAIL wr_data_a5: got %h want 00a5", wr_data); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL wr_busy_end: got %b want 0", busy); else n_pass++;
      @(negedge clk);
      n_checks++; if (wr_dv !== 1'b0) $display("FAIL wr_dv_clear: got %b want 0", wr_dv); else n_pass++;
      n_checks++; if (dv_cnt !== 1) $display("FAIL wr_dv_count: got %0d want 1", dv_cnt); else n_pass++;
      n_checks++; if (oe_cnt !== 0) $display("FAIL wr_no_drive: got %0d want 0", oe_cnt); else n_pass++;
      n_checks++; if (req_cnt !== 0) $display("FAIL wr_no_rd_req: got %0d want 0", req_cnt); else n_pass++;
   endtask

   task automatic test_read();
      logic [7:0] exp_bits;
      exp_bits = 8'h3C;
      clear_counts();
      bit_length = 4'd8;
      send_hdr(4'd1, 1'b0);
      release_line();
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (rd_req !== 1'b1) $display("FAIL rd_req_high_%0d: got %b want 1", i, rd_req); else n_pass++;
         if (i == 2) begin
            rd_valid = 1'b1; rd_data = 14'h003C;
         end
         @(negedge clk);
      end
      rd_valid = 1'b0; rd_data = 14'h1555;
      n_checks++; if (rd_req !== 1'b0) $display("FAIL rd_req_drop: got %b want 0", rd_req); else n_pass++;
      n_checks++; if (dut.line_oe !== 1'b1 || serial_port !== 1'b0) $display("FAIL rd_start_bit: got oe=%b line=%b want oe=1 line=0", dut.line_oe, serial_port); else n_pass++;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_checks++; if (dut.line_oe !== 1'b1 || serial_port !== exp_bits[i]) $display("FAIL rd_data_bit%0d: got oe=%b line=%b want oe=1 line=%b", i, dut.line_oe, serial_port, exp_bits[i]); else n_pass++;
      end
      @(negedge clk);
      n_checks++; if (dut.line_oe !== 1'b1 || serial_port !== 1'b1) $display("FAIL rd_stop_bit: got oe=%b line=%b want oe=1 line=1", dut.line_oe, serial_port); else n_pass++;
      @(negedge clk);
      n_checks++; if (dut.line_oe !== 1'b0) $display("FAIL rd_release: got %b want 0", dut.line_oe); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rd_busy_end: got %b want 0", busy); else n_pass++;
      n_checks++; if (req_cnt !== 3) $display("FAIL rd_req_cycles: got %0d want 3", req_cnt); else n_pass++;
   endtask

   task automatic test_timeout();
      clear_counts();
      bit_length = 4'd8;
      send_hdr(4'd1, 1'b0);
      release_line();
      for (int i = 0; i < 16; i++) begin
         n_checks++; if (rd_req !== 1'b1 || frame_err !== 1'b0) $display("FAIL to_wait_%0d: got req=%b err=%b want req=1 err=0", i, rd_req, frame_err); else n_pass++;
         @(negedge clk);
      end
      n_checks++; if (frame_err !== 1'b1) $display("FAIL to_frame_err: got %b want 1", frame_err); else n_pass++;
      n_checks++; if (rd_req !== 1'b0) $display("FAIL to_rd_req_low: got %b want 0", rd_req); else n_pass++;
      n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL to_state: got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
      @(negedge clk);
      n_checks++; if (frame_err !== 1'b0) $display("FAIL to_err_clear: got %b want 0", frame_err); else n_pass++;
      n_checks++; if (ferr_cnt !== 1) $display("FAIL to_err_count: got %0d want 1", ferr_cnt); else n_pass++;
      n_checks++; if (oe_cnt !== 0) $display("FAIL to_no_drive: got %0d want 0", oe_cnt); else n_pass++;
   endtask

   task automatic test_foreign();
      clear_counts();
      bit_length = 4'd8;
      send_hdr(4'd2, 1'b1);
      send_data(14'h00FF, 8);
      send_hdr(4'd2, 1'b0);
      release_line();
      repeat (3) @(negedge clk);
      // Response body that would read as a write to ID 1 if decoded as a frame.
      send_bit(1'b0);
      send_data(14'h0018, 8);
      send_bit(1'b1);
      release_line();
      @(negedge clk);
      n_checks++; if (dv_cnt !== 0) $display("FAIL fg_no_wr_dv: got %0d want 0", dv_cnt); else n_pass++;
      n_checks++; if (oe_cnt !== 0) $display("FAIL fg_no_drive: got %0d want 0", oe_cnt); else n_pass++;
      n_checks++; if (req_cnt !== 0) $display("FAIL fg_no_rd_req: got %0d want 0", req_cnt); else n_pass++;
      n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL fg_state: got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
      send_hdr(4'd1, 1'b1);
      send_data(14'h005A, 8);
      release_line();
      n_checks++; if (wr_dv !== 1'b1 || wr_data !== 14'h005A) $display("FAIL fg_next_write: got dv=%b data=%h want dv=1 data=005a", wr_dv, wr_data); else n_pass++;
      @(negedge clk);
      n_checks++; if (dv_cnt !== 1) $display("FAIL fg_dv_count: got %0d want 1", dv_cnt); else n_pass++;
   endtask

   task automatic test_lengths();
      bit_length = 4'd0;
      send_hdr(4'd1, 1'b1);
      send_data(14'h3FFF, 14);
      release_line();
      n_checks++; if (wr_dv !== 1'b1 || wr_data !== 14'h3FFF) $display("FAIL len0_write: got dv=%b data=%h want dv=1 data=3fff", wr_dv, wr_data); else n_pass++;
      @(negedge clk);
      bit_length = 4'd15;
      send_hdr(4'd1, 1'b1);
      bit_length = 4'd3;
      send_data(14'h2AAA, 14);
      release_line();
      n_checks++; if (wr_dv !== 1'b1 || wr_data !== 14'h2AAA) $display("FAIL len15_write: got dv=%b data=%h want dv=1 data=2aaa", wr_dv, wr_data); else n_pass++;
      @(negedge clk);
      bit_length = 4'd4;
      send_hdr(4'd1, 1'b1);
      bit_length = 4'd0;
      send_data(14'h000B, 3);
      n_checks++; if (wr_dv !== 1'b0) $display("FAIL len4_early_dv: got %b want 0", wr_dv); else n_pass++;
      send_bit(1'b1);
      release_line();
      n_checks++; if (wr_dv !== 1'b1 || wr_data !== 14'h000B) $display("FAIL len4_write: got dv=%b data=%h want dv=1 data=000b", wr_dv, wr_data); else n_pass++;
      @(negedge clk);
      bit_length = 4'd8;
   endtask

   task automatic test_en_abort();
      clear_counts();
      send_hdr(4'd1, 1'b1);
      send_data(14'h00FF, 3);
      en = 1'b0;
      release_line();
      @(negedge clk);
      n_checks++; if (dbg_state !== ST_IDLE || busy !== 1'b0) $display("FAIL en_wr_abort: got state=%0d busy=%b want state=%0d busy=0", dbg_state, busy, ST_IDLE); else n_pass++;
      repeat (10) @(negedge clk);
      en = 1'b1;
      repeat (2) @(negedge clk);
      send_hdr(4'd1, 1'b0);
      release_line();
      @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      n_checks++; if (rd_req !== 1'b0 || busy !== 1'b0) $display("FAIL en_rd_abort: got req=%b busy=%b want req=0 busy=0", rd_req, busy); else n_pass++;
      repeat (20) @(negedge clk);
      en = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (dv_cnt !== 0) $display("FAIL en_no_wr_dv: got %0d want 0", dv_cnt); else n_pass++;
      n_checks++; if (ferr_cnt !== 0) $display("FAIL en_no_frame_err: got %0d want 0", ferr_cnt); else n_pass++;
      n_checks++; if (wr_data !== 14'h000B) $display("FAIL en_wr_data_kept: got %h want 000b", wr_data); else n_pass++;
   endtask

   task automatic test_reset_mid_read();
      send_hdr(4'd1, 1'b0);
      release_line();
      rd_valid = 1'b1; rd_data = 14'h00FF;
      @(negedge clk);
      rd_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (dbg_state !== ST_RD_DATA || dut.line_oe !== 1'b1) $display("FAIL rr_in_rd_data: got state=%0d oe=%b want state=%0d oe=1", dbg_state, dut.line_oe, ST_RD_DATA); else n_pass++;
      #2 rstn = 1'b0;
      #1;
      n_checks++; if (dut.line_oe !== 1'b0 || serial_port !== 1'b1) $display("FAIL rr_line_release: got oe=%b line=%b want oe=0 line=1", dut.line_oe, serial_port); else n_pass++;
      n_checks++; if (wr_data !== 14'h0 || wr_dv !== 1'b0) $display("FAIL rr_wr_port: got data=%h dv=%b want data=0 dv=0", wr_data, wr_dv); else n_pass++;
      n_checks++; if (rd_req !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0) $display("FAIL rr_status: got req=%b busy=%b err=%b want 0 0 0", rd_req, busy, frame_err); else n_pass++;
      n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL rr_state: got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
      @(negedge clk);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rstn = 1'b0; en = 1'b1; bit_length = 4'd8;
      rd_data = '0; rd_valid = 1'b0;
      m_oe = 1'b0; m_val = 1'b1;
      clear_counts();
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_foreign();
      test_lengths();
      test_en_abort();
      test_reset_mid_read();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/serial_slave_port.md
# serial_slave_port

Responder end of the single-wire serial bus: decodes master-initiated frames from the shared `serial_port` line, presents write data on a local parallel port, and turns the line around to return read data. Sits at each slave node, opposite the master-side serial/parallel converter, one bit per `clk` with the same `bit_length`-programmable word size.

## Interface
- `DATA_WIDTH`, 14: maximum data bits per frame; width of the parallel ports.
- `BIT_LENGTH`, 4: width of `bit_length`.
- `ID_WIDTH`, 4: slave ID field width.
- `SLAVE_ID`, 4'd1: this node's ID.
- `RD_TIMEOUT`, 16: maximum wait cycles for local read data or a foreign response.

Ports:
- `clk` in 1: single clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `en` in 1: enable; low aborts any frame.
- `bit_length` in BIT_LENGTH: data bits per frame N; 0 or >DATA_WIDTH means DATA_WIDTH.
- `serial_port` inout 1: shared bus line; idle high (bus pull-up), driven only during read response.
- `wr_data` out DATA_WIDTH: last written word, LSB-aligned, upper bits zero.
- `wr_dv` out 1: one-cycle strobe, `wr_data` new.
- `rd_req` out 1: level request for local read data.
- `rd_data` in DATA_WIDTH: read word, sampled with `rd_valid`.
- `rd_valid` in 1: read data ready; only honoured while `rd_req` high.
- `busy` out 1: high whenever state != IDLE.
- `frame_err` out 1: one-cycle strobe on read timeout.

## Operation
- Frame: start bit 0, ID (MSB first), RW (1 = write), then N data bits LSB first. All bits sampled on rising `clk`.
- States: IDLE, ID, RW, WDATA, RD_WAIT, RD_START, RD_DATA, RD_STOP, SKIP_W, SKIP_WAIT, SKIP_RD.
- IDLE -> ID when `en` and line sampled 0. ID -> RW after ID_WIDTH bits.
- RW, ID match: write -> WDATA; read -> RD_WAIT. ID mismatch: write -> SKIP_W; read -> SKIP_WAIT.
- WDATA: shift N bits; after last, `wr_data` loaded, `wr_dv` pulsed, -> IDLE.
- RD_WAIT: `rd_req` high; on `rd_valid` latch `rd_data`, drop `rd_req`, -> RD_START. After RD_TIMEOUT cycles without `rd_valid`: `frame_err` pulse, `rd_req` low, -> IDLE.
- RD_START drives 0; RD_DATA drives N bits LSB first; RD_STOP drives 1 one cycle; then line released, -> IDLE.
- SKIP_W counts N bits, -> IDLE. SKIP_WAIT waits up to RD_TIMEOUT+1 cycles for line 0 (foreign start), then SKIP_RD counts N data + 1 stop, -> IDLE; timeout -> IDLE silently.
- `en` low in any state: next cycle IDLE, line released, `rd_req` low, no `wr_dv`, no `frame_err`.

## Timing
- Reset: `wr_data`=0, `wr_dv`=0, `rd_req`=0, `busy`=0, `frame_err`=0, line released (Z); state IDLE.
- Cycle 0 = start bit sampled. ID bits cycles 1..ID_WIDTH; RW cycle ID_WIDTH+1 (k).
- Write: data cycles k+1..k+N; `wr_dv` high cycle k+N+1, which is also IDLE and may sample the next start bit.
- Read: `rd_req` high from k+1; if `rd_valid` at cycle r, start bit driven r+1, data r+2..r+N+1, stop r+N+2, released r+N+3. Minimum RW-to-start gap: 2 cycles.
- Timeout counts from first `rd_req` cycle; `frame_err` cycle = k+RD_TIMEOUT+1.
- `bit_length` sampled once at cycle k; changes mid-frame ignored.

## Structure
- Shared package `serial_bus_pkg`: state encoding, RW_WRITE/RW_READ, START_LEVEL=0, IDLE_LEVEL=1, STOP_LEVEL=1, effective-length clamp function.
- One sub-module: `serial_bit_counter` (loadable down-counter with terminal flag), reused for ID, data, skip and timeout counts.

## Test plan
- Write ID=1, N=8, data 0xA5 -> `wr_dv` one cycle at k+9, `wr_data`=0x00A5, line never driven.
- Read ID=1, N=8, `rd_valid` at k+3 with 0x3C -> line 0, bits 0,0,1,1,1,1,0,0, stop 1, then Z; `rd_req` high k+1..k+3.
- Read ID=1, `rd_valid` never -> `frame_err` at k+17, `rd_req` low, IDLE, line Z throughout.
- Write to ID=2 then foreign read response to ID=2 -> no `wr_dv`, no drive, response start bit not decoded as a frame; next ID=1 write accepted.
- `bit_length`=0 write of 0x3FFF -> 14 bits received, `wr_data`=0x3FFF; `en` dropped mid-WDATA -> IDLE next cycle, no `wr_dv`; `rstn` low mid-RD_DATA -> line Z immediately, outputs at reset values.
